addr_counter: RTL and testbench

- Free-running read-address generator for a sample memory: e.g. the synthetic-FRB playback buffer on the Red Pitaya.
- Steps an ADDR_SIZE-bit address once every `decimate` enabled clock cycles.
- Qualifies each new address with a one-cycle `addr_valid` strobe.
- Flags completion of a full pass through the address space with `finish`.

---
 rtl/addr_counter_pkg.sv | 18 +
 rtl/addr_counter_decim_strobe.sv | 43 ++++
 rtl/addr_counter.sv | 73 +++++++
 tb/tb_addr_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/addr_counter_pkg.sv
// Shared constants and helpers for the sample-memory read-address generator.
// The decimation limit helper folds the "0 means 1" rule into a single place.
package addr_counter_pkg;

   localparam int unsigned DCNT_W = 32;

   // Terminal count for the decimation counter: D-1, where D = max(decimate, 1).
   function automatic logic [DCNT_W-1:0] div_limit(input logic [DCNT_W-1:0] decimate);
      logic [DCNT_W-1:0] lim;
      if (decimate == 32'd0) begin
         lim = 32'd0;
      end else begin
         lim = decimate - 32'd1;
      end
      return lim;
   endfunction

endpackage

// File: rtl/addr_counter_decim_strobe.sv
// Decimation counter: raises a one-cycle tick on every D-th enabled cycle.
// The >= compare lets a shrinking divisor fire immediately instead of wrapping 2^32.
module decim_strobe
   import addr_counter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DCNT_W-1:0] decimate,
   output logic              tick
);

   logic [DCNT_W-1:0] dcnt_q;
   logic [DCNT_W-1:0] dcnt_d;
   logic [DCNT_W-1:0] limit_s;

   // Next-count and tick decode; en low freezes the count.
   always_comb begin
      dcnt_d  = dcnt_q;
      tick    = 1'b0;
      limit_s = div_limit(decimate);
      if (en) begin
         if (dcnt_q >= limit_s) begin
            tick   = 1'b1;
            dcnt_d = 32'd0;
         end else begin
            dcnt_d = dcnt_q + 32'd1;
         end
      end else begin
         dcnt_d = dcnt_q;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt_q <= 32'd0;
      end else begin
         dcnt_q <= dcnt_d;
      end
   end

endmodule

// File: rtl/addr_counter.sv
// Free-running read-address generator: emits one address per decimation tick,
// strobes addr_valid with it and pulses finish on the last address of each pass.
module addr_counter
   import addr_counter_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DCNT_W-1:0]    decimate,
   output logic [ADDR_SIZE-1:0] addr,
   output logic                 addr_valid,
   output logic                 finish
);

   localparam logic [ADDR_SIZE-1:0] ADDR_MAX = {ADDR_SIZE{1'b1}};

   logic                 tick_s;
   logic [ADDR_SIZE-1:0] ptr_q;
   logic [ADDR_SIZE-1:0] ptr_d;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [ADDR_SIZE-1:0] addr_d;
   logic                 addr_valid_q;
   logic                 addr_valid_d;
   logic                 finish_q;
   logic                 finish_d;

   decim_strobe u_decim_strobe (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .decimate (decimate),
      .tick     (tick_s)
   );

   // On a tick, publish the pending pointer and advance it (wraps naturally).
   always_comb begin
      ptr_d        = ptr_q;
      addr_d       = addr_q;
      addr_valid_d = 1'b0;
      finish_d     = 1'b0;
      if (tick_s) begin
         addr_d       = ptr_q;
         addr_valid_d = 1'b1;
         finish_d     = (ptr_q == ADDR_MAX);
         ptr_d        = ptr_q + ADDR_SIZE'(1'b1);
      end else begin
         ptr_d  = ptr_q;
         addr_d = addr_q;
      end
   end

   // Pointer and output registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q        <= {ADDR_SIZE{1'b0}};
         addr_q       <= {ADDR_SIZE{1'b0}};
         addr_valid_q <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         finish_q     <= finish_d;
      end
   end

   assign addr       = addr_q;
   assign addr_valid = addr_valid_q;
   assign finish     = finish_q;

endmodule

// File: tb/tb_addr_counter.sv
// Directed self-checking bench for addr_counter (ADDR_SIZE = 8).
module tb_addr_counter;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] decimate;
   logic [7:0]  addr;
   logic        addr_valid;
   logic        finish;

   int checks;
   int failures;

   addr_counter #(.ADDR_SIZE(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .decimate   (decimate),
      .addr       (addr),
      .addr_valid (addr_valid),
      .finish     (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b0;
      decimate = 32'd4;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 1) rst = 1'b0;
         checks++;
         if (addr !== 8'd0 || addr_valid !== 1'b0 || finish !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got addr=%0d v=%b f=%b want addr=0 v=0 f=0",
                     k, addr, addr_valid, finish);
         end
      end
   endtask

   task automatic test_decimation();
      logic       ev;
      logic [7:0] ea;
      do_reset();
      decimate = 32'd4;
      en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         ev = ((k % 4) == 0);
         ea = (k >= 4) ? 8'(k / 4 - 1) : 8'd0;
         checks++;
         if (addr_valid !== ev || addr !== ea || finish !== 1'b0) begin
            failures++;
            $display("FAIL decim4 cyc=%0d got addr=%0d v=%b f=%b want addr=%0d v=%b f=0",
                     k, addr, addr_valid, finish, ea, ev);
         end
      end
   endtask

   task automatic test_wrap();
      int         nfin;
      logic [7:0] ea;
      do_reset();
      decimate = 32'd1;
      en = 1'b1;
      nfin = 0;
      for (int k = 1; k <= 520; k++) begin
         tick();
         ea = 8'((k - 1) % 256);
         if (finish === 1'b1) nfin++;
         checks++;
         if (addr_valid !== 1'b1 || addr !== ea || finish !== (ea == 8'd255)) begin
            failures++;
            $display("FAIL wrap cyc=%0d got addr=%0d v=%b f=%b want addr=%0d v=1 f=%b",
                     k, addr, addr_valid, finish, ea, (ea == 8'd255));
         end
      end
      checks++;
      if (nfin !== 2) begin
         failures++;
         $display("FAIL wrap_finish_count got %0d want 2", nfin);
      end
   endtask

   task automatic test_decimate_zero();
      do_reset();
      decimate = 32'd0;
      en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if (addr_valid !== 1'b1 || addr !== 8'(k - 1) || finish !== 1'b0) begin
            failures++;
            $display("FAIL decim0 cyc=%0d got addr=%0d v=%b want addr=%0d v=1",
                     k, addr, addr_valid, k - 1);
         end
      end
   endtask

   task automatic test_pause();
      do_reset();
      decimate = 32'd3;
      en = 1'b1;
      for (int k = 1; k <= 9; k++) tick();
      checks++;
      if (addr_valid !== 1'b1 || addr !== 8'd2) begin
         failures++;
         $display("FAIL pause_pre got addr=%0d v=%b want addr=2 v=1", addr, addr_valid);
      end
      en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (addr_valid !== 1'b0 || addr !== 8'd2 || finish !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold cyc=%0d got addr=%0d v=%b want addr=2 v=0",
                     k, addr, addr_valid);
         end
      end
      en = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (addr_valid !== (k == 3) || addr !== ((k == 3) ? 8'd3 : 8'd2)) begin
            failures++;
            $display("FAIL pause_resume cyc=%0d got addr=%0d v=%b want addr=%0d v=%b",
                     k, addr, addr_valid, (k == 3) ? 3 : 2, (k == 3));
         end
      end
   endtask

   task automatic test_decimate_change();
      logic       ev;
      logic [7:0] ea;
      do_reset();
      decimate = 32'd10;
      en = 1'b1;
      for (int k = 1; k <= 5; k++) tick();
      checks++;
      if (addr_valid !== 1'b0) begin
         failures++;
         $display("FAIL dchg_pre got v=%b want v=0", addr_valid);
      end
      decimate = 32'd2;
      for (int k = 1; k <= 5; k++) begin
         tick();
         ev = ((k % 2) == 1);
         ea = 8'((k - 1) / 2);
         checks++;
         if (addr_valid !== ev || addr !== ea) begin
            failures++;
            $display("FAIL dchg cyc=%0d got addr=%0d v=%b want addr=%0d v=%b",
                     k, addr, addr_valid, ea, ev);
         end
      end
   endtask

   task automatic test_midrun_reset();
      do_reset();
      decimate = 32'd1;
      en = 1'b1;
      for (int k = 1; k <= 38; k++) tick();
      checks++;
      if (addr !== 8'd37 || addr_valid !== 1'b1) begin
         failures++;
         $display("FAIL mrst_pre got addr=%0d v=%b want addr=37 v=1", addr, addr_valid);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (addr !== 8'd0 || addr_valid !== 1'b0 || finish !== 1'b0) begin
         failures++;
         $display("FAIL mrst_clear got addr=%0d v=%b f=%b want 0 0 0", addr, addr_valid, finish);
      end
      rst = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         tick();
         checks++;
         if (addr !== 8'(k - 1) || addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL mrst_restart cyc=%0d got addr=%0d v=%b want addr=%0d v=1",
                     k, addr, addr_valid, k - 1);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      en = 1'b0;
      decimate = 32'd4;
      test_reset();
      test_decimation();
      test_wrap();
      test_decimate_zero();
      test_pause();
      test_decimate_change();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
